uart_rx_axi: RTL and testbench

AXI4-Lite responder that deserialises an 8N1 UART line and buffers the received bytes in a FIFO for the core to read. It is the receive-side counterpart of the existing UART transmitter and sits behind the Xbar as one more slave window. Software polls STATUS and pops bytes through RXDATA. Framing and overrun errors are sticky and cleared with write-1-to-clear.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/uart_rx_axi.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_axi.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver slave: register offsets,
// AXI response codes, FSM state types and STATUS bit positions.
package uart_rx_pkg;

    localparam logic [3:0] RXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ST_NEMPTY = 0;
    localparam int ST_OVR    = 1;
    localparam int ST_FERR   = 2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wr_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received UART data; synchronous push/pop, async reset.
// Ports: push_i/data_i write, pop_i read; full_o, empty_o, count_o, head_o.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [7:0]               head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_axi.sv
// AXI4-Lite slave receiving 8N1 UART bytes into a FIFO (RXDATA/STATUS regs).
// Ports: clk, rst (async active-low), rxd serial in, AXI4-Lite AR/R/AW/W/B.
module uart_rx_axi
    import uart_rx_pkg::*;
#(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] HALF_M1 = TW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(BAUD_DIV - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       state_q;
    logic [TW-1:0]   tmr_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      shift_q;
    logic            push_q, ferr_set_q;
    logic            ovr_q, ferr_q;
    logic            fifo_full, fifo_empty, pop;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      fifo_head;
    logic [3:0]      cnt_sat;
    logic            arready_q, rvalid_q;
    logic [31:0]     rdata_q, rd_data_d;
    logic [1:0]      rresp_q, rd_resp_d;
    wr_state_t       wstate_q;
    logic            awready_q, wready_q, bvalid_q;
    logic [1:0]      bresp_q;
    logic            ar_hs, rd_fifo, rd_stat, w_hs, wr_stat;
    logic            clr_ovr, clr_ferr, ovr_set;
    logic            unused_bits;

    assign unused_bits = ^{araddr[31:4], araddr[1:0], awaddr[31:4],
                           awaddr[1:0], wdata[31:3], wdata[0], wstrb[3:1]};

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_q),
        .data_i  (shift_q),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    // Receive FSM; push/ferr pulses are registered, so the FIFO write lands
    // one cycle after the stop-bit sample while shift_q is still held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            tmr_q      <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    tmr_q <= '0;
                    if (rx_prev_q && !rx_sync_q) state_q <= START;
                end
                START: begin
                    if (tmr_q == HALF_M1) begin
                        tmr_q    <= '0;
                        bitcnt_q <= '0;
                        state_q  <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tmr_q == FULL_M1) begin
                        tmr_q    <= '0;
                        shift_q  <= {rx_sync_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) state_q <= STOP;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tmr_q == FULL_M1) begin
                        tmr_q      <= '0;
                        push_q     <= rx_sync_q;
                        ferr_set_q <= !rx_sync_q;
                        state_q    <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cnt_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);

    assign ar_hs   = arvalid && arready_q;
    assign rd_fifo = (araddr[3:2] == RXDATA_OFF[3:2]);
    assign rd_stat = (araddr[3:2] == STATUS_OFF[3:2]);
    assign pop     = ar_hs && rd_fifo && !fifo_empty;

    always_comb begin
        rd_data_d = 32'h0;
        rd_resp_d = RESP_SLVERR;
        if (rd_fifo) begin
            rd_resp_d = RESP_OKAY;
            rd_data_d = fifo_empty ? 32'h8000_0000 : {24'h0, fifo_head};
        end else if (rd_stat) begin
            rd_resp_d = RESP_OKAY;
            rd_data_d = {24'h0, cnt_sat, 1'b0, ferr_q, ovr_q, !fifo_empty};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data_d;
            rresp_q   <= rd_resp_d;
        end else if (rvalid_q && rready) begin
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
        end
    end

    // Write handshake completes in W_ACCEPT, where awready/wready are high.
    assign w_hs     = (wstate_q == W_ACCEPT);
    assign wr_stat  = (awaddr[3:2] == STATUS_OFF[3:2]);
    assign clr_ovr  = w_hs && wr_stat && wstrb[0] && wdata[ST_OVR];
    assign clr_ferr = w_hs && wr_stat && wstrb[0] && wdata[ST_FERR];
    assign ovr_set  = push_q && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            ovr_q  <= ovr_set || (ovr_q && !clr_ovr);
            ferr_q <= ferr_set_q || (ferr_q && !clr_ferr);
            unique case (wstate_q)
                W_IDLE: begin
                    if (awvalid && wvalid) begin
                        wstate_q  <= W_ACCEPT;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_ACCEPT: begin
                    wstate_q  <= W_RESP;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= awaddr[3] ? RESP_SLVERR : RESP_OKAY;
                end
                W_RESP: begin
                    if (bready) begin
                        wstate_q <= W_IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_uart_rx_axi.sv
// Self-checking bench for uart_rx_axi: UART frames and AXI accesses checked
// against a queue-based model of the receive FIFO and sticky flags.
module tb_uart_rx_axi;

    localparam int BAUD  = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    bit         m_ovr;
    bit         m_ferr;

    always #5 clk = ~clk;

    uart_rx_axi #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] m_status();
        int c;
        c = (mq.size() > 15) ? 15 : mq.size();
        return (32'(c) << 4) | (32'(m_ferr) << 2) | (32'(m_ovr) << 1)
               | 32'(mq.size() != 0);
    endfunction

    function automatic logic [31:0] m_pop();
        if (mq.size() == 0) return 32'h8000_0000;
        return {24'h0, mq.pop_front()};
    endfunction

    // Drive one 8N1 frame and apply its effect to the model.
    task automatic send(input logic [7:0] b, input bit stop);
        rxd = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BAUD);
        end
        rxd = stop;
        tick(BAUD);
        rxd = 1'b1;
        tick(4);
        if (!stop) m_ferr = 1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic axi_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r);
        int n = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        chk("ar_timeout", 32'(n < 50), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("rvalid_lat", 32'(rvalid), 32'd1);
        d = rdata;
        r = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] r);
        int n = 0;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        while (!awready && n < 50) begin
            tick();
            n++;
        end
        chk("aw_timeout", 32'(n < 50), 32'd1);
        chk("wready_with_aw", 32'(wready), 32'(awready));
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("bvalid_lat", 32'(bvalid), 32'd1);
        r = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        if (a[3:2] == 2'b01 && s[0]) begin
            if (d[1]) m_ovr = 0;
            if (d[2]) m_ferr = 0;
        end
    endtask

    task automatic rd_status(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        axi_rd(32'h4, d, r);
        chk(tag, d, m_status());
        chk({tag, "_resp"}, 32'(r), 32'd0);
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] e;
        axi_rd(32'h0, d, r);
        e = m_pop();
        chk(tag, d, e);
        chk({tag, "_resp"}, 32'(r), 32'd0);
    endtask

    initial begin
        logic [31:0] d, held;
        logic [1:0]  r;
        int          n;
        rst = 1'b0; rxd = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b0;
        tick(3);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b1;
        tick(3);

        // Basic receive
        send(8'h5A, 1'b1);
        rd_status("basic_status");
        chk("basic_status_const", m_status(), 32'h11);
        rd_data("basic_data");
        rd_data("basic_empty");

        // False start: 6 low cycles, shorter than half a bit
        rxd = 1'b0;
        tick(6);
        rxd = 1'b1;
        tick(3 * BAUD);
        rd_status("false_start");

        // Framing error and W1C
        send(8'hA5, 1'b0);
        rd_status("ferr_status");
        axi_wr(32'h4, 32'h4, 4'h1, r);
        chk("ferr_clr_bresp", 32'(r), 32'd0);
        rd_status("ferr_cleared");

        // Overrun
        for (int i = 0; i < 9; i++) send(8'(i), 1'b1);
        rd_status("ovr_status");
        for (int i = 0; i < 9; i++) rd_data($sformatf("ovr_rd%0d", i));
        axi_wr(32'h4, 32'h6, 4'h1, r);
        rd_status("ovr_cleared");

        // Randomised frames with interleaved reads
        for (int k = 0; k < 10; k++) begin
            send(8'($urandom), ($urandom % 5) != 0);
            if ($urandom % 2) rd_data($sformatf("rnd_rd%0d", k));
            if (k % 3 == 2) rd_status($sformatf("rnd_st%0d", k));
        end
        axi_wr(32'h4, $urandom, 4'h1, r);
        rd_status("rnd_w1c");
        while (mq.size() != 0) rd_data("rnd_drain");
        axi_wr(32'h4, 32'h6, 4'h1, r);

        // Read handshake stress: rready held low, single pop
        send(8'hC3, 1'b1);
        send(8'h3E, 1'b1);
        araddr = 32'h0;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        held = rdata;
        chk("hs_data", held, m_pop());
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hs_rvalid_hold", 32'(rvalid), 32'd1);
            chk("hs_rdata_hold", rdata, held);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("hs_rvalid_drop", 32'(rvalid), 32'd0);
        rd_status("hs_one_pop");

        // Write handshake: awvalid 3 cycles ahead of wvalid
        awaddr = 32'h4; wdata = 32'h0; wstrb = 4'h1;
        awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("aw_alone", 32'(awready), 32'd0);
        end
        wvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        chk("aw_w_together", 32'({awready, wready}), 32'd3);
        chk("bvalid_not_yet", 32'(bvalid), 32'd0);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_next", 32'(bvalid), 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Unmapped and RO accesses
        axi_rd(32'h8, d, r);
        chk("unm_rdata", d, 32'd0);
        chk("unm_rresp", 32'(r), 32'd2);
        axi_wr(32'hC, 32'hFFFF_FFFF, 4'hF, r);
        chk("unm_bresp", 32'(r), 32'd2);
        axi_wr(32'h0, 32'hFF, 4'hF, r);
        chk("ro_bresp", 32'(r), 32'd0);
        rd_status("after_unm");

        // Reset mid-frame with a byte still buffered
        rxd = 1'b0;
        tick(BAUD);
        rxd = 1'b1;
        tick(3 * BAUD);
        rst = 1'b0;
        tick(3);
        rxd = 1'b1;
        mq.delete();
        m_ovr = 0;
        m_ferr = 0;
        chk("midrst_arready", 32'(arready), 32'd1);
        rst = 1'b1;
        tick(4 * BAUD);
        rd_status("midrst_status");
        send(8'h3C, 1'b1);
        rd_data("midrst_3c");
        rd_status("final_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
